// File: rtl/adder_io_pkg.sv
// adder_io_pkg
//   Shared definitions for the adder front-end input stage: the operand
//   entry state encoding and the switch field layout used when capturing
//   operands from the slide switches.
package adder_io_pkg;

  // Width of each captured operand (taken from Sw[OPERAND_W-1:0]).
  localparam int OPERAND_W  = 4;
  // Switch index that supplies the carry-in during the X capture.
  localparam int CIN_SW_IDX = 4;

  // Operand entry sequence. The encoding is visible on Phase, so the
  // values are fixed explicitly. 2'd3 is unused and unreachable.
  typedef enum logic [1:0] {
    WAIT_X = 2'd0,
    WAIT_Y = 2'd1,
    READY  = 2'd2
  } state_t;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
//   Two-flop synchroniser, level debouncer and rising-edge pulse for one
//   bouncy push button.
//
//   Ports:
//     Clk       in   system clock, rising edge
//     Rst       in   synchronous active-high reset
//     BtnIn     in   raw button, asynchronous to Clk
//     BtnStable out  debounced button level
//     Press     out  one-cycle registered pulse per accepted 0->1 change
module btn_debounce #(
  parameter int DB_CYCLES = 16
) (
  input  logic Clk,
  input  logic Rst,
  input  logic BtnIn,
  output logic BtnStable,
  output logic Press
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  // Count value on which a persisting disagreement is accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [1:0]       sync_reg;
  logic             btn_s;
  logic             stable_reg;
  logic             stable_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             press_reg;
  logic             press_next;

  // sync_reg[1] is the synchronised level; sync_reg[0] is the metastability
  // catcher and is never looked at by anything else.
  assign btn_s = sync_reg[1];

  always_comb begin
    stable_next = stable_reg;
    cnt_next    = '0;
    press_next  = 1'b0;
    if (btn_s != stable_reg) begin
      if (cnt_reg == CNT_LAST) begin
        // Disagreement lasted DB_CYCLES samples: accept the new level.
        // Only a 0->1 acceptance produces a press; releases are silent.
        stable_next = btn_s;
        press_next  = btn_s;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
    // Any agreement leaves cnt_next at zero, discarding partial counts.
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      sync_reg   <= 2'b00;
      stable_reg <= 1'b0;
      cnt_reg    <= '0;
      press_reg  <= 1'b0;
    end else begin
      sync_reg   <= {sync_reg[0], BtnIn};
      stable_reg <= stable_next;
      cnt_reg    <= cnt_next;
      press_reg  <= press_next;
    end
  end

  assign BtnStable = stable_reg;
  assign Press     = press_reg;

endmodule

// File: rtl/operand_capture.sv
// operand_capture
//   Input stage for the 4-bit adder: synchronises the slide switches,
//   debounces the push button and walks a three-state entry sequence that
//   captures operand X plus carry-in, then operand Y, then clears on the
//   next press. All operand outputs come straight from registers so the
//   downstream combinational adder sees glitch-free inputs.
//
//   Ports:
//     Clk    in   system clock, rising edge
//     Rst    in   synchronous active-high reset
//     Sw     in   [7:0] raw slide switches, asynchronous
//     Btn0   in   raw push button, active-high, bouncy
//     OpX    out  [3:0] captured operand X
//     OpY    out  [3:0] captured operand Y
//     Cin    out  captured carry-in
//     Valid  out  high while a full X/Y/Cin set is held (READY)
//     Phase  out  [1:0] current state encoding for status LEDs
module operand_capture
  import adder_io_pkg::*;
#(
  parameter int DB_CYCLES = 16
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [7:0]           Sw,
  input  logic                 Btn0,
  output logic [OPERAND_W-1:0] OpX,
  output logic [OPERAND_W-1:0] OpY,
  output logic                 Cin,
  output logic                 Valid,
  output logic [1:0]           Phase
);

  // ---------------------------------------------------------------------
  // Switch synchroniser, one two-flop chain per switch
  // ---------------------------------------------------------------------
  logic [7:0] sw_meta_reg;
  logic [7:0] sw_s;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_sw_sync
      always_ff @(posedge Clk) begin
        if (Rst) begin
          sw_meta_reg[gi] <= 1'b0;
          sw_s[gi]        <= 1'b0;
        end else begin
          sw_meta_reg[gi] <= Sw[gi];
          sw_s[gi]        <= sw_meta_reg[gi];
        end
      end
    end
  endgenerate

  // Upper switches are synchronised but reserved for future mode selects.
  logic sw_spare_unused;
  assign sw_spare_unused = ^sw_s[7:5];

  // ---------------------------------------------------------------------
  // Button conditioning
  // ---------------------------------------------------------------------
  logic press;
  logic btn_stable_unused;

  btn_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_btn_debounce (
    .Clk       (Clk),
    .Rst       (Rst),
    .BtnIn     (Btn0),
    .BtnStable (btn_stable_unused),
    .Press     (press)
  );

  // ---------------------------------------------------------------------
  // Entry FSM: state register
  // ---------------------------------------------------------------------
  state_t               state_reg;
  state_t               state_next;
  logic [OPERAND_W-1:0] opx_reg;
  logic [OPERAND_W-1:0] opx_next;
  logic [OPERAND_W-1:0] opy_reg;
  logic [OPERAND_W-1:0] opy_next;
  logic                 cin_reg;
  logic                 cin_next;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg <= WAIT_X;
      opx_reg   <= '0;
      opy_reg   <= '0;
      cin_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      opx_reg   <= opx_next;
      opy_reg   <= opy_next;
      cin_reg   <= cin_next;
    end
  end

  // ---------------------------------------------------------------------
  // Entry FSM: next-state and operand load logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    opx_next   = opx_reg;
    opy_next   = opy_reg;
    cin_next   = cin_reg;
    case (state_reg)
      WAIT_X: begin
        if (press) begin
          opx_next   = sw_s[OPERAND_W-1:0];
          cin_next   = sw_s[CIN_SW_IDX];
          state_next = WAIT_Y;
        end
      end
      WAIT_Y: begin
        if (press) begin
          opy_next   = sw_s[OPERAND_W-1:0];
          state_next = READY;
        end
      end
      READY: begin
        if (press) begin
          opx_next   = '0;
          opy_next   = '0;
          cin_next   = 1'b0;
          state_next = WAIT_X;
        end
      end
      default: begin
        // Unreachable encoding: recover to the start of the sequence.
        state_next = WAIT_X;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Entry FSM: outputs, decoded from registered state only
  // ---------------------------------------------------------------------
  always_comb begin
    Valid = (state_reg == READY);
    Phase = state_reg;
  end

  assign OpX = opx_reg;
  assign OpY = opy_reg;
  assign Cin = cin_reg;

endmodule

// File: tb/tb_operand_capture.sv
// tb_operand_capture
//   Directed and randomised stimulus for operand_capture with DB_CYCLES=4.
//   The reference model records every sampled input in history arrays and
//   decides debounce acceptance by looking back over the last DB_CYCLES
//   synchronised samples, then applies the entry rules to its own state.
module tb_operand_capture;

  localparam int DB   = 4;
  localparam int HMAX = 16384;

  logic       Clk;
  logic       Rst;
  logic [7:0] Sw;
  logic       Btn0;
  logic [3:0] OpX;
  logic [3:0] OpY;
  logic       Cin;
  logic       Valid;
  logic [1:0] Phase;

  operand_capture #(
    .DB_CYCLES (DB)
  ) dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .Sw    (Sw),
    .Btn0  (Btn0),
    .OpX   (OpX),
    .OpY   (OpY),
    .Cin   (Cin),
    .Valid (Valid),
    .Phase (Phase)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_asserts = 0;
  int n_fail    = 0;

  // ---------------- reference model ----------------
  bit       btn_hist [HMAX];
  bit [7:0] sw_hist  [HMAX];
  int       cyc = 32;
  bit       m_stable;
  bit       m_press;
  int       m_state;
  bit [3:0] m_opx;
  bit [3:0] m_opy;
  bit       m_cin;

  // One rising edge of the model. Input seen by the design logic at edge k
  // is what was sampled two edges earlier (two-flop synchronisers).
  task automatic model_step();
    bit       all_diff;
    bit [7:0] sws;
    cyc++;
    btn_hist[cyc] = Btn0;
    sw_hist[cyc]  = Sw;
    if (Rst) begin
      // Cleared synchronisers and counter: older samples no longer count.
      for (int j = cyc - DB - 2; j <= cyc; j++) begin
        btn_hist[j] = 1'b0;
        sw_hist[j]  = 8'h00;
      end
      m_stable = 0; m_press = 0; m_state = 0;
      m_opx = 0; m_opy = 0; m_cin = 0;
    end else begin
      if (m_press) begin
        sws = sw_hist[cyc-2];
        if (m_state == 0) begin
          m_opx = sws[3:0]; m_cin = sws[4]; m_state = 1;
        end else if (m_state == 1) begin
          m_opy = sws[3:0]; m_state = 2;
        end else begin
          m_opx = 0; m_opy = 0; m_cin = 0; m_state = 0;
        end
      end
      // A new level is accepted once the last DB synchronised samples all
      // disagree with the currently accepted level.
      all_diff = 1'b1;
      for (int j = 0; j < DB; j++)
        if (btn_hist[cyc-2-j] == m_stable) all_diff = 1'b0;
      m_press = all_diff && !m_stable;
      if (all_diff) m_stable = !m_stable;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("opx",   32'(OpX),   32'(m_opx));
    check("opy",   32'(OpY),   32'(m_opy));
    check("cin",   32'(Cin),   32'(m_cin));
    check("valid", 32'(Valid), 32'(m_state == 2));
    check("phase", 32'(Phase), 32'(m_state));
  endtask

  // Advance one clock: model follows the edge, outputs sampled mid-low.
  task automatic tick();
    @(posedge Clk);
    model_step();
    @(negedge Clk);
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int lat;
    int hold;
    Rst  = 1'b1;
    Sw   = 8'h00;
    Btn0 = 1'b0;

    // Reset: three cycles, then first cycle after deassertion.
    ticks(3);
    Rst = 1'b0;
    tick();
    check("rst_phase", 32'(Phase), 32'd0);
    check("rst_valid", 32'(Valid), 32'd0);
    check("rst_opx",   32'(OpX),   32'd0);
    $display("reset: OpX=%0h OpY=%0h Cin=%0b Valid=%0b Phase=%0d", OpX, OpY, Cin, Valid, Phase);
    ticks(2);

    // X capture and its exact latency from the first high sample.
    Sw   = 8'h1A;
    ticks(3);
    Btn0 = 1'b1;
    lat  = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (lat < 0 && Phase == 2'd1) lat = i - 1;
    end
    check("x_latency", 32'(lat), 32'd6);
    Btn0 = 1'b0;
    ticks(10);
    check("x_opx",   32'(OpX),   32'hA);
    check("x_cin",   32'(Cin),   32'd1);
    check("x_phase", 32'(Phase), 32'd1);
    $display("capture X: OpX=%0h Cin=%0b Phase=%0d latency=%0d", OpX, Cin, Phase, lat);

    // Y capture.
    Sw = 8'h07;
    ticks(3);
    Btn0 = 1'b1;
    ticks(10);
    Btn0 = 1'b0;
    ticks(10);
    check("y_opy",   32'(OpY),   32'h7);
    check("y_valid", 32'(Valid), 32'd1);
    check("y_phase", 32'(Phase), 32'd2);
    $display("capture Y: OpY=%0h Valid=%0b Phase=%0d", OpY, Valid, Phase);

    // Bounce: toggle every 2 cycles for 20 cycles, then hold low.
    for (int i = 0; i < 10; i++) begin
      Btn0 = ~Btn0;
      ticks(2);
    end
    Btn0 = 1'b0;
    ticks(10);
    check("bounce_phase", 32'(Phase), 32'd2);
    check("bounce_opx",   32'(OpX),   32'hA);
    $display("bounce: Phase=%0d OpX=%0h OpY=%0h", Phase, OpX, OpY);

    // Wrap from READY clears everything.
    Btn0 = 1'b1;
    ticks(10);
    Btn0 = 1'b0;
    ticks(10);
    check("wrap_opx",   32'(OpX),   32'd0);
    check("wrap_opy",   32'(OpY),   32'd0);
    check("wrap_cin",   32'(Cin),   32'd0);
    check("wrap_phase", 32'(Phase), 32'd0);
    check("wrap_valid", 32'(Valid), 32'd0);
    $display("wrap: OpX=%0h OpY=%0h Cin=%0b Phase=%0d Valid=%0b", OpX, OpY, Cin, Phase, Valid);

    // Long hold yields exactly one capture.
    Sw = 8'hE9;
    ticks(3);
    Btn0 = 1'b1;
    ticks(100);
    Btn0 = 1'b0;
    ticks(10);
    check("hold_phase", 32'(Phase), 32'd1);
    check("hold_opx",   32'(OpX),   32'h9);
    check("hold_cin",   32'(Cin),   32'd0);
    $display("hold: OpX=%0h Cin=%0b Phase=%0d", OpX, Cin, Phase);

    // Reset two counts into a debounce; held button then presses once.
    Sw = 8'h15;
    ticks(3);
    Btn0 = 1'b1;
    ticks(4);
    Rst = 1'b1;
    ticks(3);
    Rst = 1'b0;
    lat = -1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 1) check("midrst_phase", 32'(Phase), 32'd0);
      if (lat < 0 && Phase == 2'd1) lat = i;
    end
    check("midrst_latency", 32'(lat), 32'(DB + 3));
    Btn0 = 1'b0;
    ticks(10);
    check("midrst_opx", 32'(OpX), 32'h5);
    check("midrst_cin", 32'(Cin), 32'd1);
    $display("reset mid-debounce: OpX=%0h Cin=%0b Phase=%0d latency=%0d", OpX, Cin, Phase, lat);

    // Randomised button levels, switch values and occasional resets.
    for (int k = 0; k < 250; k++) begin
      if ($urandom_range(0, 2) == 0) Sw = 8'($urandom);
      if ($urandom_range(0, 24) == 0) begin
        Rst = 1'b1;
        ticks($urandom_range(1, 2));
        Rst = 1'b0;
      end
      Btn0 = 1'($urandom_range(0, 1));
      hold = $urandom_range(1, 12);
      ticks(hold);
      $display("random %0d: Btn0=%0b hold=%0d Sw=%02h OpX=%0h OpY=%0h Cin=%0b Phase=%0d",
               k, Btn0, hold, Sw, OpX, OpY, Cin, Phase);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
